// File: rtl/t_reg_pkg.sv
// Shared definitions for the T-register sequence controller: state encoding
// and default sizing.
package t_reg_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 9;
    localparam int unsigned PASS_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        STORE = 2'd3
    } state_t;

endpackage

// File: rtl/beat_counter.sv
// Counts words shifted into the T chain during a load; flags the beat
// that will complete the chain.
module beat_counter
    import t_reg_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/t_reg_seq_ctrl.sv
// Load/store sequencer for a chain of T registers: shifts DEPTH words in,
// then hands the chain to a consumer and issues one store per accepted pass.
module t_reg_seq_ctrl
    import t_reg_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned PASS_W = PASS_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    input  logic                       m_last,
    output logic                       t_en,
    output logic                       t_sel,
    output logic [$clog2(DEPTH+1)-1:0] beat_cnt,
    output logic [PASS_W-1:0]          pass_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned BEAT_W = $clog2(DEPTH + 1);

    state_t state;
    state_t state_nxt;
    logic   beat_tc;
    logic   beat_inc;
    logic   beat_clr;
    logic   load_go;

    assign load_go  = (state == IDLE) && start && !abort;
    assign beat_inc = (state == SHIFT) && s_valid && !abort;
    assign beat_clr = abort || load_go;

    beat_counter #(
        .DEPTH (DEPTH),
        .CNT_W (BEAT_W)
    ) u_beat_counter (
        .clk  (clk),
        .rstn (rstn),
        .clr  (beat_clr),
        .inc  (beat_inc),
        .cnt  (beat_cnt),
        .tc   (beat_tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nxt = SHIFT;
                SHIFT:   if (s_valid && beat_tc) state_nxt = FULL;
                FULL:    if (m_ready) state_nxt = m_last ? IDLE : STORE;
                STORE:   state_nxt = FULL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake/status flags come only from the state register; t_en is the
    // one output allowed to follow s_valid and abort within the cycle.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        t_en    = 1'b0;
        t_sel   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            SHIFT: begin
                s_ready = 1'b1;
                t_en    = s_valid && !abort;
            end
            FULL: begin
                m_valid = 1'b1;
            end
            STORE: begin
                t_en  = !abort;
                t_sel = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_cnt <= '0;
        end else if (abort || load_go) begin
            pass_cnt <= '0;
        end else if (state == STORE) begin
            pass_cnt <= pass_cnt + PASS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
        end else begin
            done <= !abort && (state == FULL) && m_ready && m_last;
        end
    end

endmodule

// File: tb/tb_t_reg_seq_ctrl.sv
// Scoreboard bench for t_reg_seq_ctrl at DEPTH=4, PASS_W=8: a behavioural
// model predicts every cycle's outputs, which are queued and compared.
module tb_t_reg_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int PW    = 8;
    localparam int BW    = $clog2(DEPTH + 1);
    localparam int OW    = 6 + BW + PW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b0, m_last = 1'b0;
    logic s_ready, m_valid, t_en, t_sel, busy, done;
    logic [BW-1:0] beat_cnt;
    logic [PW-1:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [OW-1:0] sb[$];

    int md_st, md_beat, md_pass;
    bit md_done;

    t_reg_seq_ctrl #(.DEPTH(DEPTH), .PASS_W(PW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .t_en(t_en), .t_sel(t_sel),
        .beat_cnt(beat_cnt), .pass_cnt(pass_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exceeded time limit", cyc);
        $fatal(1);
    end

    // Reference behaviour of the controller, written from the requirements.
    always @(posedge clk or negedge rstn) begin
        if (!rstn || abort) begin
            md_st = 0; md_beat = 0; md_pass = 0; md_done = 0;
        end else begin
            md_done = (md_st == 2) && m_ready && m_last;
            case (md_st)
                0: if (start) begin md_st = 1; md_beat = 0; md_pass = 0; end
                1: if (s_valid) begin md_beat++; if (md_beat == DEPTH) md_st = 2; end
                2: if (m_ready) md_st = m_last ? 0 : 3;
                3: begin md_pass = (md_pass + 1) % 256; md_st = 2; end
                default: md_st = 0;
            endcase
        end
    end

    function automatic logic [OW-1:0] observed();
        return {t_en, t_sel, s_ready, m_valid, busy, done, beat_cnt, pass_cnt};
    endfunction

    function automatic logic [OW-1:0] expected();
        logic te;
        te = !abort && ((md_st == 1 && s_valid) || md_st == 3);
        return {te, 1'(md_st == 3), 1'(md_st == 1), 1'(md_st == 2), 1'(md_st != 0),
                md_done, BW'(md_beat), PW'(md_pass)};
    endfunction

    // v = {start, abort, s_valid, m_ready, m_last}
    task automatic step(input logic [4:0] v);
        @(negedge clk);
        {start, abort, s_valid, m_ready, m_last} = v;
        #1;
        sb.push_back(expected());
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        #12;
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_hold obs=%h exp=%h", observed(), {OW{1'b0}});
        end
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(5'b00000);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
        end
    endtask

    task automatic test_load();
        logic [4:0] v[6] = '{5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
        logic [OW-1:0] e;
        int ten = 0, first_mv = -1;
        for (int i = 0; i < 6; i++) begin
            step(v[i]);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL load cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            if (t_en && !t_sel) ten++;
            if (m_valid && first_mv < 0) first_mv = i;
        end
        checks++;
        if (ten != 4 || first_mv != 5) begin
            errors++; $display("FAIL load_latency t_en=%0d mv_cycle=%0d exp 4 and 5", ten, first_mv);
        end
    endtask

    task automatic test_passes();
        logic [4:0] v[9] = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00000,
                             5'b00011, 5'b00000, 5'b00000};
        logic [OW-1:0] e;
        int stores = 0, dones = 0;
        for (int i = 0; i < 9; i++) begin
            step(v[i]);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL passes cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            if (t_en && t_sel) stores++;
            if (done) dones++;
            if (i == 6) begin
                checks++;
                if (pass_cnt !== 8'd3) begin
                    errors++; $display("FAIL pass_cnt3 obs=%0d exp=3", pass_cnt);
                end
            end
        end
        checks++;
        if (stores != 3 || dones != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL passes_summary stores=%0d dones=%0d busy=%b exp 3 1 0",
                               stores, dones, busy);
        end
    endtask

    task automatic test_gapped();
        logic [4:0] v[9] = '{5'b10000, 5'b00100, 5'b00000, 5'b10000, 5'b00100, 5'b00100,
                             5'b00000, 5'b00100, 5'b00000};
        logic [OW-1:0] e;
        int ten = 0;
        for (int i = 0; i < 9; i++) begin
            step(v[i]);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL gapped cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            if (t_en !== s_valid) begin
                checks++; errors++;
                $display("FAIL gapped_align cyc=%0d t_en=%b s_valid=%b", cyc, t_en, s_valid);
            end
            if (t_en) ten++;
        end
        checks++;
        if (ten != 4 || m_valid !== 1'b1) begin
            errors++; $display("FAIL gapped_count t_en=%0d m_valid=%b exp 4 1", ten, m_valid);
        end
    endtask

    task automatic test_abort();
        logic [4:0] v[12] = '{5'b01011, 5'b00000, 5'b10000, 5'b00100, 5'b00100, 5'b01100,
                              5'b00000, 5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
        logic [OW-1:0] e;
        for (int i = 0; i < 12; i++) begin
            step(v[i]);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL abort cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            if (i == 5) begin
                checks++;
                if (t_en !== 1'b0 || beat_cnt !== 3'd2) begin
                    errors++; $display("FAIL abort_t_en t_en=%b beat=%0d exp 0 2", t_en, beat_cnt);
                end
            end
            if (i == 1 || i == 6) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || beat_cnt !== 3'd0) begin
                    errors++; $display("FAIL abort_idle busy=%b done=%b beat=%0d exp 0 0 0",
                                       busy, done, beat_cnt);
                end
            end
        end
        step(5'b01011);
        e = sb.pop_front(); checks++;
        if (observed() !== e) begin
            errors++; $display("FAIL abort_full cyc=%0d obs=%h exp=%h", cyc, observed(), e);
        end
        step(5'b00000);
        e = sb.pop_front(); checks++;
        if (observed() !== e || done !== 1'b0) begin
            errors++; $display("FAIL abort_nodone cyc=%0d obs=%h exp=%h", cyc, observed(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] v[6] = '{5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00010};
        logic [OW-1:0] e;
        for (int i = 0; i < 6; i++) begin
            step(v[i]);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL areset_pre cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
        end
        @(negedge clk);
        {start, abort, s_valid, m_ready, m_last} = 5'b00000;
        #1;
        checks++;
        if (t_en !== 1'b1 || t_sel !== 1'b1) begin
            errors++; $display("FAIL areset_store t_en=%b t_sel=%b exp 1 1", t_en, t_sel);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (observed() !== '0) begin
            errors++; $display("FAIL areset_async obs=%h exp=%h", observed(), {OW{1'b0}});
        end
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(i == 0 ? 5'b10000 : (i == 5 ? 5'b00000 : 5'b00100));
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL areset_reload cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
        end
        checks++;
        if (m_valid !== 1'b1 || beat_cnt !== 3'd4 || pass_cnt !== 8'd0) begin
            errors++; $display("FAIL areset_clean m_valid=%b beat=%0d pass=%0d exp 1 4 0",
                               m_valid, beat_cnt, pass_cnt);
        end
        step(5'b01000);
        void'(sb.pop_front());
    endtask

    task automatic test_wrap();
        logic [OW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            step(i == 0 ? 5'b10000 : 5'b00100);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL wrap_load cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
        end
        for (int p = 0; p < 256; p++) begin
            step(5'b00010);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL wrap_req cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            step(5'b00000);
            e = sb.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL wrap_store cyc=%0d obs=%h exp=%h", cyc, observed(), e);
            end
            if (p == 254 || p == 255) begin
                step(5'b00000);
                void'(sb.pop_front());
                checks++;
                if (pass_cnt !== (p == 254 ? 8'd255 : 8'd0) || m_valid !== 1'b1) begin
                    errors++; $display("FAIL wrap_cnt pass=%0d m_valid=%b exp %0d 1",
                                       pass_cnt, m_valid, (p == 254) ? 255 : 0);
                end
            end
        end
        step(5'b00011);
        e = sb.pop_front(); checks++;
        if (observed() !== e) begin
            errors++; $display("FAIL wrap_final cyc=%0d obs=%h exp=%h", cyc, observed(), e);
        end
        step(5'b00000);
        e = sb.pop_front(); checks++;
        if (observed() !== e || done !== 1'b1) begin
            errors++; $display("FAIL wrap_done cyc=%0d obs=%h exp=%h", cyc, observed(), e);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_passes();
        test_gapped();
        test_abort();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
